// File: rtl/avst_mem_writer_pkg.sv
// rtl/avst_mem_writer_pkg.sv - shared types and constants for the stream-to-memory writer
package avst_mem_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_BASE    = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_WRITTEN = 2'd3;

    localparam int CTRL_GO_BIT       = 0;
    localparam int CTRL_CLR_DONE_BIT = 1;
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_DONE_BIT     = 1;
    localparam int STAT_EMPTY_BIT    = 2;

    localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/avst_mem_writer_if.sv
// rtl/avst_mem_writer_if.sv - control slave, stream sink and write master bundle
interface avst_mem_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]            avs_avalonslave_address;
    logic                  avs_avalonslave_read;
    logic                  avs_avalonslave_write;
    logic [31:0]           avs_avalonslave_writedata;
    logic [31:0]           avs_avalonslave_readdata;
    logic                  avs_avalonslave_waitrequest;

    logic                  asi_avalonst_valid;
    logic [DATA_WIDTH-1:0] asi_avalonst_data;
    logic                  asi_avalonst_ready;

    logic [ADDR_WIDTH-1:0] avm_avalonmaster_address;
    logic                  avm_avalonmaster_write;
    logic [DATA_WIDTH-1:0] avm_avalonmaster_writedata;
    logic                  avm_avalonmaster_waitrequest;

    modport slave (
        input  avs_avalonslave_address, avs_avalonslave_read, avs_avalonslave_write,
        input  avs_avalonslave_writedata,
        output avs_avalonslave_readdata, avs_avalonslave_waitrequest,
        input  asi_avalonst_valid, asi_avalonst_data,
        output asi_avalonst_ready,
        output avm_avalonmaster_address, avm_avalonmaster_write, avm_avalonmaster_writedata,
        input  avm_avalonmaster_waitrequest
    );

    modport master (
        output avs_avalonslave_address, avs_avalonslave_read, avs_avalonslave_write,
        output avs_avalonslave_writedata,
        input  avs_avalonslave_readdata, avs_avalonslave_waitrequest,
        output asi_avalonst_valid, asi_avalonst_data,
        input  asi_avalonst_ready,
        input  avm_avalonmaster_address, avm_avalonmaster_write, avm_avalonmaster_writedata,
        output avm_avalonmaster_waitrequest
    );

endinterface

// File: rtl/avst_mem_writer_fifo.sv
// rtl/avst_mem_writer_fifo.sv - writer_fifo: synchronous word buffer with flop-sourced head
module writer_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head (and the master writedata) reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/avst_mem_writer.sv
// rtl/avst_mem_writer.sv - stream-to-memory writer top; WRITER_IRQ_EN adds ins_irq_irq
module avst_mem_writer
    import avst_mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic               csi_clock_clk,
    input  logic               csi_clock_reset_n,
    avst_mem_writer_if.slave   bus
`ifdef WRITER_IRQ_EN
    ,
    output logic               ins_irq_irq
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t                 state, state_nx;
    logic [ADDR_WIDTH-1:0]  base_reg, base_l;
    logic [COUNT_WIDTH-1:0] count_reg, count_l, accepted, written;
    logic                   done_bit;
    logic                   fifo_full, fifo_empty;
    logic [LW-1:0]          fifo_level;
    logic [DATA_WIDTH-1:0]  fifo_head;
    logic                   ctrl_wr, go, clr_done, accept, pop, ready, mwrite;
    logic [31:0]            rdata;

    assign ctrl_wr  = bus.avs_avalonslave_write && (bus.avs_avalonslave_address == REG_CTRL);
    assign go       = ctrl_wr && bus.avs_avalonslave_writedata[CTRL_GO_BIT];
    assign clr_done = ctrl_wr && bus.avs_avalonslave_writedata[CTRL_CLR_DONE_BIT];

    assign ready  = (state == RUN) && !fifo_full && (accepted < count_l);
    assign mwrite = (state == RUN) && (fifo_level != '0);
    assign accept = bus.asi_avalonst_valid && ready;
    assign pop    = mwrite && !bus.avm_avalonmaster_waitrequest;

    writer_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (csi_clock_clk),
        .rst_n (csi_clock_reset_n),
        .push  (accept),
        .din   (bus.asi_avalonst_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) state <= IDLE;
        else                    state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = (count_reg == '0) ? DONE : RUN;
            RUN:     if (pop && ((written + 1'b1) == count_l)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The running transfer works from latched copies so software may reprogram early.
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            base_reg  <= '0;
            count_reg <= '0;
            base_l    <= '0;
            count_l   <= '0;
            accepted  <= '0;
            written   <= '0;
            done_bit  <= 1'b0;
        end else begin
            if (bus.avs_avalonslave_write && (bus.avs_avalonslave_address == REG_BASE))
                base_reg <= ADDR_WIDTH'(bus.avs_avalonslave_writedata);
            if (bus.avs_avalonslave_write && (bus.avs_avalonslave_address == REG_COUNT))
                count_reg <= COUNT_WIDTH'(bus.avs_avalonslave_writedata);
            if ((state == IDLE) && go) begin
                base_l   <= base_reg;
                count_l  <= count_reg;
                accepted <= '0;
                written  <= '0;
            end else begin
                if (accept) accepted <= accepted + 1'b1;
                if (pop)    written  <= written + 1'b1;
            end
            // Setting wins over a coincident clear.
            if (state == DONE)                           done_bit <= 1'b1;
            else if (clr_done || ((state == IDLE) && go)) done_bit <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.avs_avalonslave_read) begin
            case (bus.avs_avalonslave_address)
                REG_CTRL: begin
                    rdata[STAT_BUSY_BIT]  = (state != IDLE);
                    rdata[STAT_DONE_BIT]  = done_bit;
                    rdata[STAT_EMPTY_BIT] = fifo_empty;
                end
                REG_BASE:    rdata = 32'(base_reg);
                REG_COUNT:   rdata = 32'(count_reg);
                REG_WRITTEN: rdata = 32'(written);
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.avs_avalonslave_readdata    = rdata;
    assign bus.avs_avalonslave_waitrequest = 1'b0;
    assign bus.asi_avalonst_ready          = ready;
    assign bus.avm_avalonmaster_write      = mwrite;
    assign bus.avm_avalonmaster_writedata  = fifo_head;
    assign bus.avm_avalonmaster_address    =
        base_l + (ADDR_WIDTH'(written) * ADDR_WIDTH'(WORD_STRIDE));

`ifdef WRITER_IRQ_EN
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) ins_irq_irq <= 1'b0;
        else                    ins_irq_irq <= done_bit;
    end
`endif

endmodule
